// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encoding and width default for the counter and its scoreboard
package counter_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP    = 2'b00;
  localparam mode_t MODE_DOWN  = 2'b01;
  localparam mode_t MODE_DOWN3 = 2'b10;
  localparam mode_t MODE_LOAD  = 2'b11;

endpackage

// File: rtl/counter_scoreboard_if.sv
// rtl/counter_scoreboard_if.sv - stimulus/prediction bundle; checker signals exist only with SCOREBOARD_CHECK_EN
interface counter_scoreboard_if #(
  parameter int WIDTH = counter_pkg::WIDTH_DEFAULT
) ();

  logic               enable;
  counter_pkg::mode_t modo;
  logic [WIDTH-1:0]   D;
  logic [WIDTH-1:0]   sb_Q;
  logic               sb_rco;

`ifdef SCOREBOARD_CHECK_EN
  logic [WIDTH-1:0]   dut_Q;
  logic               dut_rco;
  logic               mismatch;
  logic [15:0]        err_count;

  modport master (output enable, modo, D, dut_Q, dut_rco,
                  input  sb_Q, sb_rco, mismatch, err_count);
  modport slave  (input  enable, modo, D, dut_Q, dut_rco,
                  output sb_Q, sb_rco, mismatch, err_count);
`else
  modport master (output enable, modo, D, input sb_Q, sb_rco);
  modport slave  (input enable, modo, D, output sb_Q, sb_rco);
`endif

endinterface

// File: rtl/counter_scoreboard_sb_next_state.sv
// rtl/counter_scoreboard_sb_next_state.sv - combinational next value and ripple-carry prediction
module sb_next_state import counter_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] sb_Q,
  input  mode_t            modo,
  input  logic [WIDTH-1:0] D,
  input  logic             enable,
  output logic [WIDTH-1:0] q_next,
  output logic             rco_next
);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] res;

  // One extra bit catches the carry/borrow; a load never sets it.
  always_comb begin
    ext      = {1'b0, sb_Q};
    res      = ext;
    q_next   = sb_Q;
    rco_next = 1'b0;
    if (enable) begin
      case (modo)
        MODE_UP:    res = ext + (WIDTH+1)'(1);
        MODE_DOWN:  res = ext - (WIDTH+1)'(1);
        MODE_DOWN3: res = ext - (WIDTH+1)'(3);
        default:    res = {1'b0, D};
      endcase
      q_next   = res[WIDTH-1:0];
      rco_next = res[WIDTH];
    end
  end

endmodule

// File: rtl/counter_scoreboard.sv
// rtl/counter_scoreboard.sv - registered reference model of the multi-mode counter; SCOREBOARD_CHECK_EN adds the DUT comparator
module counter_scoreboard import counter_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_scoreboard_if.slave  bus
);

  logic [WIDTH-1:0] q_next;
  logic             rco_next;

  sb_next_state #(.WIDTH(WIDTH)) u_next (
    .sb_Q     (bus.sb_Q),
    .modo     (bus.modo),
    .D        (bus.D),
    .enable   (bus.enable),
    .q_next   (q_next),
    .rco_next (rco_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sb_Q   <= '0;
      bus.sb_rco <= 1'b0;
    end else begin
      bus.sb_Q   <= q_next;
      bus.sb_rco <= rco_next;
    end
  end

`ifdef SCOREBOARD_CHECK_EN
  logic differ;

  assign differ = (bus.dut_Q != bus.sb_Q) || (bus.dut_rco != bus.sb_rco);

  // Error counter sticks at all-ones rather than wrapping back to a clean-looking value.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mismatch  <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.mismatch <= differ;
      if (differ && (bus.err_count != 16'hFFFF))
        bus.err_count <= bus.err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_scoreboard.sv
// tb/tb_counter_scoreboard.sv - directed and random checks of counter_scoreboard against an arithmetic model
module tb_counter_scoreboard;
  import counter_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_scoreboard_if #(.WIDTH(W)) bus ();

  counter_scoreboard #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int mq       = 0;
  bit mrco     = 1'b0;
`ifdef SCOREBOARD_CHECK_EN
  int merr     = 0;
  bit mmis     = 1'b0;
  bit inject   = 1'b0;
`endif

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
  endtask

  // Drive one cycle of stimulus at the falling edge, advance the model, compare at the next falling edge.
  task automatic step(input bit rst, input bit en, input logic [1:0] m,
                      input logic [3:0] d, input string tag);
    reset      = rst;
    bus.enable = en;
    bus.modo   = m;
    bus.D      = d;
`ifdef SCOREBOARD_CHECK_EN
    bus.dut_Q   = inject ? 4'((mq + 1) % MOD) : 4'(mq);
    bus.dut_rco = mrco;
    if (rst) begin
      mmis = 1'b0;
      merr = 0;
    end else begin
      mmis = inject;
      if (inject && merr < 65535) merr++;
    end
`endif
    if (rst) begin
      mq   = 0;
      mrco = 1'b0;
    end else if (!en) begin
      mrco = 1'b0;
    end else begin
      case (m)
        2'b00: begin mrco = (mq == MOD - 1); mq = (mq + 1) % MOD;       end
        2'b01: begin mrco = (mq == 0);       mq = (mq + MOD - 1) % MOD; end
        2'b10: begin mrco = (mq < 3);        mq = (mq + MOD - 3) % MOD; end
        default: begin mrco = 1'b0;          mq = int'(d);              end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_q", tag),   16'(bus.sb_Q),   16'(mq));
    check($sformatf("%s_rco", tag), 16'(bus.sb_rco), 16'(mrco));
`ifdef SCOREBOARD_CHECK_EN
    check($sformatf("%s_mis", tag), 16'(bus.mismatch), 16'(mmis));
    check($sformatf("%s_err", tag), bus.err_count,     16'(merr));
`endif
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.modo   = MODE_UP;
    bus.D      = '0;
`ifdef SCOREBOARD_CHECK_EN
    bus.dut_Q   = '0;
    bus.dut_rco = 1'b0;
`endif
    @(negedge clk);

    step(1'b1, 1'b1, MODE_UP, 4'd0, "rst0");
    step(1'b1, 1'b1, MODE_UP, 4'd0, "rst1");
    step(1'b0, 1'b1, MODE_UP, 4'd0, "rel");

    step(1'b0, 1'b1, MODE_LOAD, 4'd14, "ld14");
    step(1'b0, 1'b1, MODE_UP,   4'd0,  "up15");
    step(1'b0, 1'b1, MODE_UP,   4'd0,  "upwrap");

    step(1'b0, 1'b1, MODE_LOAD,  4'd1, "ld1");
    step(1'b0, 1'b1, MODE_DOWN3, 4'd0, "d3wrap");
    step(1'b0, 1'b1, MODE_DOWN3, 4'd0, "d3_11");
    step(1'b0, 1'b1, MODE_LOAD,  4'd0, "ld0");
    step(1'b0, 1'b1, MODE_DOWN,  4'd0, "dnwrap");
    step(1'b0, 1'b1, MODE_LOAD,  4'd2, "ld2");
    step(1'b0, 1'b1, MODE_DOWN3, 4'd0, "d3from2");
    step(1'b0, 1'b0, MODE_LOAD,  4'd9, "holdclr");

    step(1'b0, 1'b1, MODE_LOAD, 4'd7, "ld7");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "hold");

    step(1'b0, 1'b1, MODE_LOAD, 4'd8, "ld8");
    step(1'b0, 1'b1, MODE_UP,   4'd0, "up9");
    step(1'b1, 1'b1, MODE_UP,   4'd0, "midrst");
    step(1'b0, 1'b1, MODE_UP,   4'd0, "resume");

`ifdef SCOREBOARD_CHECK_EN
    inject = 1'b1;
    step(1'b0, 1'b1, MODE_UP, 4'd0, "inj0");
    step(1'b0, 1'b1, MODE_UP, 4'd0, "inj1");
    inject = 1'b0;
    step(1'b0, 1'b1, MODE_UP, 4'd0, "inj_end");
    step(1'b0, 1'b1, MODE_UP, 4'd0, "inj_clean");
`endif

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
